// File: rtl/zero_regfile.sv
// Parametrised register file with an optional hardwired-zero entry 0,
// two combinational read ports with optional write-first bypass, and a debug port.
module zero_regfile #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd,
   input  logic [ADDR_W-1:0] ra1,
   output logic [WIDTH-1:0]  rd1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd2,
   input  logic [ADDR_W-1:0] dbg_a,
   output logic [WIDTH-1:0]  dbg_d
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_ok;

   // A write only lands when not in reset and not aimed at a hardwired-zero entry;
   // the same qualifier gates bypass, so a suppressed write is never forwarded.
   assign wr_ok = we && !rst && !(ZERO_REG && (wa == '0));

   always_comb begin
      // NOTE: default the whole next-state array to the current contents first, so
      // every element is assigned on every path and no latch is inferred.
      mem_d = mem_q;
      if (rst) begin
         // NOTE: this array is reset on purpose: after reset every entry must read 0,
         // which rules out a plain RAM macro for this block.
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else if (wr_ok) begin
         mem_d[wa] = wd;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Later assignments win: zero entry > bypass > stored value.
   always_comb begin
      rd1 = mem_q[ra1];
      if (BYPASS && wr_ok && (wa == ra1)) rd1 = wd;
      if (ZERO_REG && (ra1 == '0))        rd1 = '0;
   end

   always_comb begin
      rd2 = mem_q[ra2];
      if (BYPASS && wr_ok && (wa == ra2)) rd2 = wd;
      if (ZERO_REG && (ra2 == '0))        rd2 = '0;
   end

   always_comb begin
      dbg_d = mem_q[dbg_a];
      if (ZERO_REG && (dbg_a == '0)) dbg_d = '0;
   end

endmodule

// File: tb/tb_zero_regfile.sv
// Scoreboard bench for zero_regfile: one default instance (zero entry, bypass)
// and one plain instance (no zero entry, no bypass) share the same stimulus.
module tb_zero_regfile;

   logic        clk = 1'b0;
   logic        rst, we;
   logic [4:0]  wa, ra1, ra2, dbg_a;
   logic [31:0] wd;
   logic [31:0] rd1_a, rd2_a, dbg_d_a;
   logic [31:0] rd1_b, rd2_b, dbg_d_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t    sb_q[$];
   logic [31:0] model_a [32];
   logic [31:0] model_b [32];

   always #5 clk = ~clk;

   zero_regfile #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .rd1(rd1_a), .ra2(ra2), .rd2(rd2_a),
      .dbg_a(dbg_a), .dbg_d(dbg_d_a)
   );

   zero_regfile #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_plain (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .rd1(rd1_b), .ra2(ra2), .rd2(rd2_b),
      .dbg_a(dbg_a), .dbg_d(dbg_d_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected read value from the behavioural description, for one configuration.
   function automatic logic [31:0] exp_read(input bit zr, input bit bp, input bit is_dbg,
                                            input logic [4:0] a, input logic [31:0] stored);
      if (zr && a == 5'd0) return 32'h0;
      if (bp && !is_dbg && we && !rst && !(zr && wa == 5'd0) && wa == a) return wd;
      return stored;
   endfunction

   function automatic logic [31:0] pick(input int sel);
      case (sel)
         0: return rd1_a;
         1: return rd2_a;
         2: return dbg_d_a;
         3: return rd1_b;
         4: return rd2_b;
         default: return dbg_d_b;
      endcase
   endfunction

   task automatic cyc(input logic r, input logic w, input logic [4:0] wa_i, input logic [31:0] wd_i,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                      input string tag);
      @(negedge clk);
      rst = r; we = w; wa = wa_i; wd = wd_i; ra1 = a1; ra2 = a2; dbg_a = ad;
      sb_q.push_back('{{tag, ".rd1_a"}, 0, exp_read(1'b1, 1'b1, 1'b0, a1, model_a[a1])});
      sb_q.push_back('{{tag, ".rd2_a"}, 1, exp_read(1'b1, 1'b1, 1'b0, a2, model_a[a2])});
      sb_q.push_back('{{tag, ".dbg_a"}, 2, exp_read(1'b1, 1'b1, 1'b1, ad, model_a[ad])});
      sb_q.push_back('{{tag, ".rd1_b"}, 3, exp_read(1'b0, 1'b0, 1'b0, a1, model_b[a1])});
      sb_q.push_back('{{tag, ".rd2_b"}, 4, exp_read(1'b0, 1'b0, 1'b0, a2, model_b[a2])});
      sb_q.push_back('{{tag, ".dbg_b"}, 5, exp_read(1'b0, 1'b0, 1'b1, ad, model_b[ad])});
      #1;
      while (sb_q.size() > 0) begin
         sb_item_t it;
         it = sb_q.pop_front();
         check(it.tag, pick(it.sel), it.exp);
      end
      // Model state as it will be after the coming rising edge.
      if (r) begin
         for (int i = 0; i < 32; i++) begin
            model_a[i] = 32'h0;
            model_b[i] = 32'h0;
         end
      end else if (w) begin
         if (wa_i != 5'd0) model_a[wa_i] = wd_i;
         model_b[wa_i] = wd_i;
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_a = '0;
      for (int i = 0; i < 32; i++) begin
         model_a[i] = 32'h0;
         model_b[i] = 32'h0;
      end
      @(posedge clk);

      // Reset with a write pending, then sweep all addresses.
      cyc(1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd3, 5'd3, "reset");
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i), "sweep");
      end

      cyc(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd5, "wr5");
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, "rd5");

      cyc(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, "wr0");
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "rd0");

      cyc(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd0, "wr7a");
      cyc(1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7, 5'd7, "byp7");
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7, "rd7");

      cyc(1'b0, 1'b1, 5'd9, 32'hA5, 5'd0, 5'd0, 5'd0, "wr9");
      cyc(1'b1, 1'b1, 5'd9, 32'h5A, 5'd9, 5'd9, 5'd9, "rst9");
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9, "rd9");

      // Random traffic, biased so reads often collide with the write address.
      for (int n = 0; n < 1000; n++) begin
         logic       r, w;
         logic [4:0] a_w, a1, a2, ad;
         r   = ($urandom_range(0, 99) == 0);
         w   = ($urandom_range(0, 2) != 0);
         a_w = 5'($urandom_range(0, 31));
         a1  = ($urandom_range(0, 2) == 0) ? a_w : 5'($urandom_range(0, 31));
         a2  = ($urandom_range(0, 2) == 0) ? a_w : 5'($urandom_range(0, 31));
         ad  = ($urandom_range(0, 2) == 0) ? a_w : 5'($urandom_range(0, 31));
         cyc(r, w, a_w, $urandom, a1, a2, ad, "rand");
      end

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
